matmul_axis_coproc: RTL and testbench
=====================================

# matmul_axis_coproc

Parametrised AXI-Stream matrix-vector multiply coprocessor.
- Receives an A_ROWS×A_COLS unsigned matrix A (row-major), then an A_COLS×1 vector B, on one slave stream.
- Computes R = (A·B) >> RES_SHIFT, with each element saturated to DATA_WIDTH bits.
- Returns the A_ROWS results on one master stream.
- Sits between the DMA's MM2S and S2MM channels; successor to the fixed 2×4, 8-bit coprocessor, adding size parameters, output saturation, full backpressure handling and frame-error detection.

## Interface
- A_ROWS, 2, rows of A; number of output words (≥1)
- A_COLS, 4, columns of A; length of B (≥1)
- DATA_WIDTH, 8, operand/result width in bits (1..16)
- RES_SHIFT, 8, right shift applied to each accumulated dot product (0..2·DATA_WIDTH)
- ACLK  in  1  single clock; everything is sampled on its rising edge
- ARESETN  in  1  synchronous, active-low reset
- S_AXIS_TREADY  out  1  ready to accept an input word
- S_AXIS_TDATA  in  32  input word; only bits [DATA_WIDTH-1:0] are used
- S_AXIS_TLAST  in  1  marks the final input word of a frame
- S_AXIS_TVALID  in  1  input word valid
- M_AXIS_TVALID  out  1  output word valid
- M_AXIS_TDATA  out  32  result, zero-extended from DATA_WIDTH bits
- M_AXIS_TLAST  out  1  marks the final result (row A_ROWS-1)
- M_AXIS_TREADY  in  1  downstream ready
- FRAME_ERR  out  1  one-cycle pulse when input TLAST does not match the frame length

## Operation
- Frame: N_IN = A_ROWS·A_COLS + A_COLS words.
  - Words 0..A_ROWS·A_COLS-1 are A[i][j], stored at index i·A_COLS+j.
  - The remaining A_COLS words are B[j].
- States: IDLE → RECV → COMPUTE → SEND → RECV.
- IDLE: entered on reset; moves to RECV after one cycle.
- RECV: S_AXIS_TREADY=1. Each TVALID&TREADY handshake stores one word and increments the input counter.
  - Handshake with TLAST=1 at count < N_IN-1: discard the frame, pulse FRAME_ERR, reset the counter, stay in RECV.
  - Handshake at count = N_IN-1: go to COMPUTE. If TLAST=0 on this word, pulse FRAME_ERR; the frame is still processed.
- COMPUTE: one multiply-accumulate per cycle, A_ROWS·A_COLS cycles in total, row by row.
  - The accumulator is cleared at the start of each row.
  - When a row finishes, its result is written to the result register file.
  - The last row finishing moves the state to SEND.
- SEND: results are presented in order, row 0 first.
  - TDATA and TLAST are held stable while TVALID=1 and TREADY=0.
  - TLAST=1 only on row A_ROWS-1.
  - The handshake on the last row moves the state to RECV.
- Arithmetic:
  - Products are unsigned, 2·DATA_WIDTH bits wide.
  - Accumulator width is 2·DATA_WIDTH + clog2(A_COLS) bits; it never wraps.
  - result = acc >> RES_SHIFT. If result ≥ 2^DATA_WIDTH, output 2^DATA_WIDTH-1.
- S_AXIS_TREADY=0 outside RECV. Input words offered during COMPUTE or SEND are not accepted.

## Timing
- Reset: when ARESETN=0 at a clock edge, the block goes to IDLE and clears all counters and the accumulator. Values after that edge:
  - S_AXIS_TREADY, M_AXIS_TVALID, M_AXIS_TLAST, FRAME_ERR: all 0.
  - M_AXIS_TDATA: 0.
- First ready: S_AXIS_TREADY=1 from the second rising edge after ARESETN returns high.
- Reset mid-operation: reset in any state abandons the frame and its results. No partial output is emitted afterwards.
- Input throughput: one word per cycle while TVALID stays high.
- Latency: M_AXIS_TVALID rises exactly A_ROWS·A_COLS+1 edges after the edge that accepts the last input word.
- Output throughput: one word per cycle while TREADY=1. Any TREADY stall pattern is tolerated with no loss or duplication.
- FRAME_ERR: asserted for exactly the one cycle following the offending handshake.
- Back-to-back frames: S_AXIS_TREADY=1 on the cycle after the final output handshake.
- All outputs are registered; there is no combinational path from input to output.

## Test plan
Scenarios 1–5 use the default parameters.
1. A row0 = 0x10 ×4, row1 = 0x01,0x02,0x03,0x04, B = 0x20 ×4, TLAST on word 11, TREADY held 1 → outputs 0x00000008, then 0x00000001 with TLAST=1; TVALID rises 9 edges after the last input handshake.
2. All 12 words = 0xFF → both outputs 0x000000FF (1016 saturated), FRAME_ERR stays 0.
3. Scenario 1 with M_AXIS_TREADY toggling 1,0,0,1 → each word held stable through the stall; exactly 2 handshakes; TLAST only on the second.
4. TLAST=1 on word 5, then a full correct frame (scenario 1 data) → FRAME_ERR pulses once on the aborted frame; only one result pair (0x08, 0x01) appears.
5. ARESETN=0 for one cycle during SEND, between the two outputs → TVALID=0 from the next edge; no further output; S_AXIS_TREADY=1 two edges after release; the next frame gives correct results.
6. Parameters A_ROWS=3, A_COLS=2, DATA_WIDTH=12, RES_SHIFT=0; A = 1,2,3,4,5,6, B = 10,20 → outputs 50, 110, 170, with TLAST on 170.

Source files
------------

// File: rtl/matmul_axis_coproc.sv
// AXI-Stream matrix-vector multiply coprocessor: R = sat((A*B) >> RES_SHIFT).
// Ports: ACLK/ARESETN, slave S_AXIS_* (A then B), master M_AXIS_* (results), FRAME_ERR pulse.
module matmul_axis_coproc #(
  parameter int A_ROWS     = 2,
  parameter int A_COLS     = 4,
  parameter int DATA_WIDTH = 8,
  parameter int RES_SHIFT  = 8
) (
  input  logic        ACLK,
  input  logic        ARESETN,
  output logic        S_AXIS_TREADY,
  input  logic [31:0] S_AXIS_TDATA,
  input  logic        S_AXIS_TLAST,
  input  logic        S_AXIS_TVALID,
  output logic        M_AXIS_TVALID,
  output logic [31:0] M_AXIS_TDATA,
  output logic        M_AXIS_TLAST,
  input  logic        M_AXIS_TREADY,
  output logic        FRAME_ERR
);

  localparam int NA   = A_ROWS * A_COLS;
  localparam int N_IN = NA + A_COLS;
  localparam int CW   = (N_IN > 1) ? $clog2(N_IN) : 1;
  localparam int RW   = (A_ROWS > 1) ? $clog2(A_ROWS) : 1;
  localparam int KW   = (A_COLS > 1) ? $clog2(A_COLS) : 1;
  localparam int AW   = 2 * DATA_WIDTH + $clog2(A_COLS);

  localparam logic [CW-1:0] IN_LAST = CW'(N_IN - 1);
  localparam logic [RW-1:0] R_LAST  = RW'(A_ROWS - 1);
  localparam logic [KW-1:0] K_LAST  = KW'(A_COLS - 1);
  localparam logic [DATA_WIDTH-1:0] DMAX = '1;

  typedef enum logic [1:0] {
    IDLE,
    RECV,
    COMPUTE,
    SEND
  } state_t;

  state_t                state_q;
  logic [DATA_WIDTH-1:0] mem_q [N_IN];
  logic [DATA_WIDTH-1:0] res_q [A_ROWS];
  logic [CW-1:0]         cnt_q;
  logic [KW-1:0]         col_q;
  logic [RW-1:0]         row_q;
  logic [AW-1:0]         acc_q;
  logic                  tready_q;
  logic                  tvalid_q;
  logic                  tlast_q;
  logic                  ferr_q;
  logic [DATA_WIDTH-1:0] tdata_q;

  logic [CW-1:0]         bidx;
  logic [AW-1:0]         prod;
  logic [AW-1:0]         acc_d;
  logic [AW-1:0]         shr;
  logic [DATA_WIDTH-1:0] sat;
  logic [RW-1:0]         row_nx;
  logic                  unused_hi;

  assign unused_hi = ^S_AXIS_TDATA[31:DATA_WIDTH];

  // cnt_q doubles as the flat A index while computing
  always_comb begin
    bidx   = CW'(NA) + CW'(col_q);
    prod   = AW'(mem_q[cnt_q]) * AW'(mem_q[bidx]);
    acc_d  = ((col_q == '0) ? '0 : acc_q) + prod;
    shr    = acc_d >> RES_SHIFT;
    sat    = (shr > AW'(DMAX)) ? DMAX : shr[DATA_WIDTH-1:0];
    row_nx = row_q + RW'(1);
  end

  always_ff @(posedge ACLK) begin
    if (!ARESETN) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      col_q    <= '0;
      row_q    <= '0;
      acc_q    <= '0;
      tready_q <= 1'b0;
      tvalid_q <= 1'b0;
      tlast_q  <= 1'b0;
      ferr_q   <= 1'b0;
      tdata_q  <= '0;
    end else begin
      ferr_q <= 1'b0;
      unique case (state_q)
        IDLE: state_q <= RECV;
        RECV: begin
          tready_q <= 1'b1;
          if (S_AXIS_TVALID && tready_q) begin
            mem_q[cnt_q] <= S_AXIS_TDATA[DATA_WIDTH-1:0];
            if (cnt_q == IN_LAST) begin
              state_q  <= COMPUTE;
              tready_q <= 1'b0;
              cnt_q    <= '0;
              col_q    <= '0;
              row_q    <= '0;
              ferr_q   <= !S_AXIS_TLAST;
            end else if (S_AXIS_TLAST) begin
              ferr_q <= 1'b1;
              cnt_q  <= '0;
            end else begin
              cnt_q <= cnt_q + CW'(1);
            end
          end
        end
        COMPUTE: begin
          acc_q <= acc_d;
          cnt_q <= cnt_q + CW'(1);
          if (col_q == K_LAST) begin
            col_q        <= '0;
            res_q[row_q] <= sat;
            if (row_q == R_LAST) begin
              state_q <= SEND;
              row_q   <= '0;
              cnt_q   <= '0;
            end else begin
              row_q <= row_nx;
            end
          end else begin
            col_q <= col_q + KW'(1);
          end
        end
        SEND: begin
          // first cycle loads row 0; afterwards each handshake advances
          if (!tvalid_q) begin
            tvalid_q <= 1'b1;
            tdata_q  <= res_q[row_q];
            tlast_q  <= (row_q == R_LAST);
          end else if (M_AXIS_TREADY) begin
            if (tlast_q) begin
              tvalid_q <= 1'b0;
              tlast_q  <= 1'b0;
              tready_q <= 1'b1;
              row_q    <= '0;
              state_q  <= RECV;
            end else begin
              row_q   <= row_nx;
              tdata_q <= res_q[row_nx];
              tlast_q <= (row_nx == R_LAST);
            end
          end
        end
      endcase
    end
  end

  assign S_AXIS_TREADY = tready_q;
  assign M_AXIS_TVALID = tvalid_q;
  assign M_AXIS_TDATA  = 32'(tdata_q);
  assign M_AXIS_TLAST  = tlast_q;
  assign FRAME_ERR     = ferr_q;

endmodule

// File: tb/tb_matmul_axis_coproc.sv
// Scoreboard bench for matmul_axis_coproc: default 2x4 instance and a 3x2 instance.
// Expected results are queued as frames are driven and popped as outputs appear.
module tb_matmul_axis_coproc;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        s_tready, s_tvalid, s_tlast;
  logic [31:0] s_tdata;
  logic        m_tvalid, m_tready, m_tlast, ferr;
  logic [31:0] m_tdata;

  logic        s1_tready, s1_tvalid, s1_tlast;
  logic [31:0] s1_tdata;
  logic        m1_tvalid, m1_tready, m1_tlast, ferr1;
  logic [31:0] m1_tdata;

  matmul_axis_coproc dut (
    .ACLK(clk), .ARESETN(rst_n),
    .S_AXIS_TREADY(s_tready), .S_AXIS_TDATA(s_tdata),
    .S_AXIS_TLAST(s_tlast), .S_AXIS_TVALID(s_tvalid),
    .M_AXIS_TVALID(m_tvalid), .M_AXIS_TDATA(m_tdata),
    .M_AXIS_TLAST(m_tlast), .M_AXIS_TREADY(m_tready),
    .FRAME_ERR(ferr)
  );

  matmul_axis_coproc #(
    .A_ROWS(3), .A_COLS(2), .DATA_WIDTH(12), .RES_SHIFT(0)
  ) dut1 (
    .ACLK(clk), .ARESETN(rst_n),
    .S_AXIS_TREADY(s1_tready), .S_AXIS_TDATA(s1_tdata),
    .S_AXIS_TLAST(s1_tlast), .S_AXIS_TVALID(s1_tvalid),
    .M_AXIS_TVALID(m1_tvalid), .M_AXIS_TDATA(m1_tdata),
    .M_AXIS_TLAST(m1_tlast), .M_AXIS_TREADY(m1_tready),
    .FRAME_ERR(ferr1)
  );

  int nerr = 0;
  int nchk = 0;
  int hs = 0;
  int hs1 = 0;
  int ferrs = 0;
  logic [32:0] sb[$];
  logic [32:0] sb1[$];
  logic        stall_q = 1'b0;
  logic [32:0] held_q = '0;

  task automatic check(input string tag, input logic [32:0] got,
                       input logic [32:0] exp);
    nchk++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!rst_n) begin
      stall_q <= 1'b0;
    end else begin
      if (stall_q) begin
        check("hold_v", 33'(m_tvalid), 33'd1);
        check("hold_d", {m_tlast, m_tdata}, held_q);
      end
      if (m_tvalid && m_tready) begin
        hs <= hs + 1;
        if (sb.size() == 0) check("unexpected", 33'(sb.size()), 33'd1);
        else check("out", {m_tlast, m_tdata}, sb.pop_front());
      end
      stall_q <= m_tvalid && !m_tready;
      held_q  <= {m_tlast, m_tdata};
      if (ferr) ferrs <= ferrs + 1;
    end
  end

  always @(negedge clk) begin
    if (rst_n && m1_tvalid && m1_tready) begin
      hs1 <= hs1 + 1;
      if (sb1.size() == 0) check("unexpected1", 33'(sb1.size()), 33'd1);
      else check("out1", {m1_tlast, m1_tdata}, sb1.pop_front());
    end
  end

  task automatic push_word(input logic [31:0] d, input logic l);
    int n = 0;
    s_tvalid = 1'b1;
    s_tdata  = d;
    s_tlast  = l;
    while (!s_tready && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    if (!s_tready) check("s_rdy_timeout", 33'd0, 33'd1);
    @(posedge clk); #1;
    s_tvalid = 1'b0;
    s_tlast  = 1'b0;
  endtask

  task automatic push1(input logic [31:0] d, input logic l);
    int n = 0;
    s1_tvalid = 1'b1;
    s1_tdata  = d;
    s1_tlast  = l;
    while (!s1_tready && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    if (!s1_tready) check("s1_rdy_timeout", 33'd0, 33'd1);
    @(posedge clk); #1;
    s1_tvalid = 1'b0;
    s1_tlast  = 1'b0;
  endtask

  task automatic send_frame(input logic [31:0] w[12], input int nw,
                            input int lp);
    for (int i = 0; i < nw; i++) push_word(w[i], i == lp);
  endtask

  task automatic model0(input logic [31:0] w[12]);
    int acc;
    logic [31:0] a32;
    for (int r = 0; r < 2; r++) begin
      acc = 0;
      for (int c = 0; c < 4; c++)
        acc += int'(w[r*4+c][7:0]) * int'(w[8+c][7:0]);
      acc = acc >>> 8;
      if (acc > 255) acc = 255;
      a32 = 32'(acc);
      sb.push_back({r == 1, a32});
    end
  endtask

  task automatic wait_tvalid(output int n);
    n = 0;
    while (!m_tvalid && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    if (!m_tvalid) check("tvalid_timeout", 33'd0, 33'd1);
  endtask

  task automatic wait_drain(input string tag);
    int n = 0;
    while (sb.size() != 0 && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    check(tag, 33'(sb.size()), 33'd0);
  endtask

  logic [31:0] f1[12] = '{32'h10, 32'h10, 32'h10, 32'h10,
                          32'h01, 32'h02, 32'h03, 32'h04,
                          32'h20, 32'h20, 32'h20, 32'h20};
  logic [31:0] f2[12] = '{default: 32'hFF};
  logic [31:0] f6[8]  = '{32'd1, 32'd2, 32'd3, 32'd4,
                          32'd5, 32'd6, 32'd10, 32'd20};

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  initial begin
    int n, e, h0, acc;
    logic [31:0] a32;
    s_tvalid = 0; s_tlast = 0; s_tdata = '0; m_tready = 1;
    s1_tvalid = 0; s1_tlast = 0; s1_tdata = '0; m1_tready = 1;
    rst_n = 0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_srdy", 33'(s_tready), 33'd0);
    check("rst_tv", 33'(m_tvalid), 33'd0);
    check("rst_tl", 33'(m_tlast), 33'd0);
    check("rst_ferr", 33'(ferr), 33'd0);
    check("rst_td", 33'(m_tdata), 33'd0);
    rst_n = 1;
    @(posedge clk); #1;
    check("rdy_e1", 33'(s_tready), 33'd0);
    @(posedge clk); #1;
    check("rdy_e2", 33'(s_tready), 33'd1);
    check("rdy1_e2", 33'(s1_tready), 33'd1);

    // basic frame, latency, back-to-back ready
    model0(f1);
    send_frame(f1, 12, 11);
    wait_tvalid(n);
    check("latency", 33'(n), 33'd9);
    wait_drain("drain_s1");
    check("b2b_rdy", 33'(s_tready), 33'd1);

    // saturation
    e = ferrs;
    model0(f2);
    send_frame(f2, 12, 11);
    wait_drain("drain_s2");
    check("ferr_s2", 33'(ferrs - e), 33'd0);

    // output backpressure 1,0,0,1
    m_tready = 0;
    model0(f1);
    send_frame(f1, 12, 11);
    wait_tvalid(n);
    @(posedge clk); #1;
    @(posedge clk); #1;
    h0 = hs;
    m_tready = 1;
    @(posedge clk); #1;
    m_tready = 0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    m_tready = 1;
    @(posedge clk); #1;
    check("hs_s3", 33'(hs - h0), 33'd2);
    check("sb_s3", 33'(sb.size()), 33'd0);
    check("tv_s3", 33'(m_tvalid), 33'd0);

    // early TLAST aborts, then a good frame
    e = ferrs;
    h0 = hs;
    send_frame(f2, 6, 5);
    check("rdy_abort", 33'(s_tready), 33'd1);
    model0(f1);
    send_frame(f1, 12, 11);
    wait_drain("drain_s4");
    check("ferr_s4", 33'(ferrs - e), 33'd1);
    check("hs_s4", 33'(hs - h0), 33'd2);

    // missing TLAST: flagged but processed
    e = ferrs;
    model0(f1);
    send_frame(f1, 12, -1);
    wait_drain("drain_nolast");
    check("ferr_nolast", 33'(ferrs - e), 33'd1);

    // reset between the two outputs
    m_tready = 0;
    model0(f1);
    send_frame(f1, 12, 11);
    wait_tvalid(n);
    m_tready = 1;
    @(posedge clk); #1;
    m_tready = 0;
    rst_n = 0;
    @(posedge clk); #1;
    check("rst5_tv", 33'(m_tvalid), 33'd0);
    check("rst5_srdy", 33'(s_tready), 33'd0);
    rst_n = 1;
    sb.delete();
    h0 = hs;
    m_tready = 1;
    @(posedge clk); #1;
    check("rst5_e1", 33'(s_tready), 33'd0);
    @(posedge clk); #1;
    check("rst5_e2", 33'(s_tready), 33'd1);
    repeat (15) @(posedge clk);
    #1;
    check("rst5_noout", 33'(hs - h0), 33'd0);
    model0(f1);
    send_frame(f1, 12, 11);
    wait_drain("drain_s5");

    // 3x2, 12-bit, no shift
    for (int r = 0; r < 3; r++) begin
      acc = 0;
      for (int c = 0; c < 2; c++)
        acc += int'(f6[r*2+c]) * int'(f6[6+c]);
      if (acc > 4095) acc = 4095;
      a32 = 32'(acc);
      sb1.push_back({r == 2, a32});
    end
    h0 = hs1;
    for (int i = 0; i < 8; i++) push1(f6[i], i == 7);
    n = 0;
    while (sb1.size() != 0 && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    check("drain_s6", 33'(sb1.size()), 33'd0);
    check("hs_s6", 33'(hs1 - h0), 33'd3);

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
